// File: rtl/accm_pkg.sv
// Shared definitions for the ACCM accumulator job sequencer: FSM encoding and default widths.
package accm_pkg;

    localparam int XW_DEF = 8;
    localparam int AW_DEF = 11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CLR   = ST_CLR,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/accm.sv
// ACCM accumulator datapath: AW-bit register that adds an XW-bit sample per enabled cycle
// and keeps the carry of the most recent add until the next one.
module accm #(
    parameter int XW = accm_pkg::XW_DEF,
    parameter int AW = accm_pkg::AW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ce,
    input  logic [XW-1:0] x,
    output logic [AW-1:0] acc,
    output logic          co
);

    logic [AW-1:0] acc_r;
    logic          co_r;

    // accumulate register with synchronous clear; no reset by design
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_r <= '0;
            co_r  <= 1'b0;
        end else if (ce) begin
            {co_r, acc_r} <= {1'b0, acc_r} + {{(AW - XW + 1){1'b0}}, x};
        end else begin
            acc_r <= acc_r;
            co_r  <= co_r;
        end
    end

    assign acc = acc_r;
    assign co  = co_r;

endmodule

// File: rtl/accm_ext_cnt.sv
// Carry-extension counter: counts accumulator carry-outs into EW extra sum bits
// and flags a wrap of the extension itself.
module accm_ext_cnt #(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ce,
    input  logic          co,
    output logic [EW-1:0] ext,
    output logic          ovf
);

    logic          co_chk_r;
    logic [EW-1:0] ext_r;
    logic          ovf_r;

    // co is only meaningful the cycle after an add, hence the one-cycle co_chk qualifier
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            co_chk_r <= 1'b0;
            ext_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            co_chk_r <= ce;
            if (co_chk_r && co) begin
                ext_r <= ext_r + EW'(1);
                if (&ext_r) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

    assign ext = ext_r;
    assign ovf = ovf_r;

endmodule

// File: rtl/accm_seq.sv
// Job sequencer for the ACCM accumulator: clears it, streams n samples into it and reports a
// carry-extended sum. Define ACCM_SEQ_TIMEOUT_EN to abort stalled jobs after TMO idle cycles.
module accm_seq
    import accm_pkg::*;
#(
    parameter int XW  = XW_DEF,
    parameter int AW  = AW_DEF,
    parameter int NW  = 8,
    parameter int EW  = 8,
    parameter int TMO = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NW-1:0]    n,
    input  logic             s_valid,
    input  logic [XW-1:0]    s_data,
    output logic             s_ready,
    output logic             acc_clr,
    output logic             acc_ce,
    output logic [XW-1:0]    acc_x,
    input  logic [AW-1:0]    acc_in,
    input  logic             acc_co,
    output logic             busy,
    output logic             done,
    output logic [EW+AW-1:0] sum,
    output logic             ovf,
    output logic             err
);

    state_t           state_r;
    logic [NW-1:0]    rem_r;
    logic             s_ready_r;
    logic             acc_clr_r;
    logic             busy_r;
    logic             done_r;
    logic             zero_r;
    logic [EW+AW-1:0] sum_r;
    logic             ovf_r;
    logic             beat_s;
    logic [XW-1:0]    acc_x_s;
    logic [EW-1:0]    ext_s;
    logic             ext_ovf_s;

`ifdef ACCM_SEQ_TIMEOUT_EN
    localparam int SW = $clog2(TMO + 1);
    logic [SW-1:0] stall_r;
    logic          err_job_r;
    logic          err_r;
`endif

    // s_ready_r is high exactly while in RUN, so a beat needs no state decode
    always_comb begin
        beat_s = s_ready_r & s_valid;
        if (beat_s) begin
            acc_x_s = s_data;
        end else begin
            acc_x_s = '0;
        end
    end

    // sequencer FSM with rem/stall counters and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            rem_r     <= '0;
            s_ready_r <= 1'b0;
            acc_clr_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            zero_r    <= 1'b0;
            sum_r     <= '0;
            ovf_r     <= 1'b0;
`ifdef ACCM_SEQ_TIMEOUT_EN
            stall_r   <= '0;
            err_job_r <= 1'b0;
            err_r     <= 1'b0;
`endif
        end else begin
            acc_clr_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // busy still high here means this is the done cycle: start is not yet taken
                    if (busy_r) begin
                        busy_r <= 1'b0;
                    end else if (start) begin
                        busy_r <= 1'b1;
`ifdef ACCM_SEQ_TIMEOUT_EN
                        err_job_r <= 1'b0;
`endif
                        if (n != '0) begin
                            rem_r     <= n;
                            zero_r    <= 1'b0;
                            acc_clr_r <= 1'b1;
                            state_r   <= S_CLR;
                        end else begin
                            zero_r  <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end
                end
                S_CLR: begin
                    s_ready_r <= 1'b1;
`ifdef ACCM_SEQ_TIMEOUT_EN
                    stall_r   <= '0;
`endif
                    state_r   <= S_RUN;
                end
                S_RUN: begin
                    if (beat_s) begin
                        rem_r <= rem_r - NW'(1);
`ifdef ACCM_SEQ_TIMEOUT_EN
                        stall_r <= '0;
`endif
                        if (rem_r == NW'(1)) begin
                            s_ready_r <= 1'b0;
                            state_r   <= S_DRAIN;
                        end
                    end
`ifdef ACCM_SEQ_TIMEOUT_EN
                    else if (stall_r == SW'(TMO - 1)) begin
                        s_ready_r <= 1'b0;
                        err_job_r <= 1'b1;
                        state_r   <= S_DRAIN;
                    end else begin
                        stall_r <= stall_r + SW'(1);
                    end
`endif
                end
                S_DRAIN: begin
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    done_r <= 1'b1;
                    if (zero_r) begin
                        sum_r <= '0;
                        ovf_r <= 1'b0;
                    end else begin
                        sum_r <= {ext_s, acc_in};
                        ovf_r <= ext_ovf_s;
                    end
`ifdef ACCM_SEQ_TIMEOUT_EN
                    err_r <= err_job_r;
`endif
                    state_r <= S_IDLE;
                end
                default: begin
                    s_ready_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    accm_ext_cnt #(
        .EW (EW)
    ) u_ext (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr_r),
        .ce  (beat_s),
        .co  (acc_co),
        .ext (ext_s),
        .ovf (ext_ovf_s)
    );

    assign s_ready = s_ready_r;
    assign acc_clr = acc_clr_r;
    assign acc_ce  = beat_s;
    assign acc_x   = acc_x_s;
    assign busy    = busy_r;
    assign done    = done_r;
    assign sum     = sum_r;
    assign ovf     = ovf_r;
`ifdef ACCM_SEQ_TIMEOUT_EN
    assign err     = err_r;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_accm_seq.sv
// Directed self-checking bench for accm_seq driving two ACCM accumulators (EW=8 and EW=2).
module tb_accm_seq;

    logic        clk = 1'b0;
    logic        rst, start, s_valid;
    logic [7:0]  n, s_data;

    logic        s_ready, acc_clr, acc_ce, acc_co, busy, done, ovf, err;
    logic [7:0]  acc_x;
    logic [10:0] acc_in;
    logic [18:0] sum;

    logic        s_ready2, acc_clr2, acc_ce2, acc_co2, busy2, done2, ovf2, err2;
    logic [7:0]  acc_x2;
    logic [10:0] acc_in2;
    logic [12:0] sum2;

    int tests = 0;
    int fails = 0;
    int ce_cnt = 0, clr_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    accm_seq #(.XW(8), .AW(11), .NW(8), .EW(8), .TMO(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .acc_clr(acc_clr), .acc_ce(acc_ce), .acc_x(acc_x),
        .acc_in(acc_in), .acc_co(acc_co), .busy(busy), .done(done), .sum(sum),
        .ovf(ovf), .err(err)
    );
    accm #(.XW(8), .AW(11)) u_acc (
        .clk(clk), .clr(acc_clr), .ce(acc_ce), .x(acc_x), .acc(acc_in), .co(acc_co)
    );

    accm_seq #(.XW(8), .AW(11), .NW(8), .EW(2), .TMO(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .n(n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready2), .acc_clr(acc_clr2), .acc_ce(acc_ce2), .acc_x(acc_x2),
        .acc_in(acc_in2), .acc_co(acc_co2), .busy(busy2), .done(done2), .sum(sum2),
        .ovf(ovf2), .err(err2)
    );
    accm #(.XW(8), .AW(11)) u_acc2 (
        .clk(clk), .clr(acc_clr2), .ce(acc_ce2), .x(acc_x2), .acc(acc_in2), .co(acc_co2)
    );

    always @(posedge clk) begin
        if (acc_ce)  ce_cnt   <= ce_cnt + 1;
        if (acc_clr) clr_cnt  <= clr_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // issues a job with s_valid held high; returns in the done cycle
    task automatic run_job(input logic [7:0] nn, input logic [7:0] xx,
                           output int cyc, output logic bok);
        logic got;
        got = 1'b0;
        bok = 1'b1;
        cyc = 0;
        start = 1'b1; n = nn; s_data = xx; s_valid = 1'b1;
        while (!got && cyc < 700) begin
            tick();
            cyc++;
            start = 1'b0;
            if (busy !== 1'b1) bok = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        s_valid = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int   cyc, c0, k0, d0;
        logic bok, got;

        rst = 1'b1; start = 1'b0; n = 8'd0; s_valid = 1'b0; s_data = 8'd0;
        tick(); tick();
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_acc_clr", {31'd0, acc_clr}, 32'd0);
        check("rst_acc_ce",  {31'd0, acc_ce},  32'd0);
        check("rst_acc_x",   {24'd0, acc_x},   32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_done",    {31'd0, done},    32'd0);
        check("rst_sum",     {13'd0, sum},     32'd0);
        check("rst_ovf",     {31'd0, ovf},     32'd0);
        check("rst_err",     {31'd0, err},     32'd0);
        rst = 1'b0;
        tick();

        // basic sum: 5 x 3
        c0 = ce_cnt; k0 = clr_cnt;
        run_job(8'd5, 8'd3, cyc, bok);
        check("basic_latency", cyc, 32'd9);
        check("basic_busy",    {31'd0, bok}, 32'd1);
        check("basic_sum",     {13'd0, sum}, 32'd15);
        check("basic_ovf",     {31'd0, ovf}, 32'd0);
        check("basic_err",     {31'd0, err}, 32'd0);
        check("basic_ce_cnt",  ce_cnt - c0, 32'd5);
        check("basic_clr_cnt", clr_cnt - k0, 32'd1);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_not_busy",  {31'd0, busy}, 32'd0);

        // back-to-back: started in the first IDLE cycle after done
        run_job(8'd1, 8'd200, cyc, bok);
        check("b2b_latency", cyc, 32'd5);
        check("b2b_sum",     {13'd0, sum}, 32'd200);
        tick();

        // carry extension and extension wrap on the EW=2 instance
        run_job(8'd255, 8'd255, cyc, bok);
        check("carry_latency", cyc, 32'd259);
        check("carry_sum",     {13'd0, sum}, 32'd65025);
        check("carry_ovf",     {31'd0, ovf}, 32'd0);
        check("wrap_done",     {31'd0, done2}, 32'd1);
        check("wrap_sum",      {19'd0, sum2}, 32'd7681);
        check("wrap_ovf",      {31'd0, ovf2}, 32'd1);
        tick();

        // zero count: straight to done, no clear and no add
        c0 = ce_cnt; k0 = clr_cnt;
        run_job(8'd0, 8'd9, cyc, bok);
        check("zero_latency", cyc, 32'd2);
        check("zero_sum",     {13'd0, sum}, 32'd0);
        check("zero_ce_cnt",  ce_cnt - c0, 32'd0);
        check("zero_clr_cnt", clr_cnt - k0, 32'd0);
        check("zero_ovf2",    {31'd0, ovf2}, 32'd0);
        tick();

        // start while busy is ignored
        d0 = done_cnt; c0 = ce_cnt;
        start = 1'b1; n = 8'd3; s_data = 8'd2; s_valid = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; n = 8'd9;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("busy_start_dones", done_cnt - d0, 32'd1);
        check("busy_start_sum",   {13'd0, sum}, 32'd6);
        check("busy_start_beats", ce_cnt - c0, 32'd3);
        s_valid = 1'b0;
        tick();

        // reset mid-job
        start = 1'b1; n = 8'd20; s_data = 8'd1; s_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_busy",    {31'd0, busy}, 32'd1);
        check("mid_s_ready", {31'd0, s_ready}, 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_busy",    {31'd0, busy}, 32'd0);
        check("mrst_s_ready", {31'd0, s_ready}, 32'd0);
        check("mrst_acc_ce",  {31'd0, acc_ce}, 32'd0);
        check("mrst_acc_x",   {24'd0, acc_x}, 32'd0);
        check("mrst_acc_clr", {31'd0, acc_clr}, 32'd0);
        check("mrst_done",    {31'd0, done}, 32'd0);
        check("mrst_sum",     {13'd0, sum}, 32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (3) tick();
        check("mrst_no_done", done_cnt - d0, 32'd0);
        run_job(8'd2, 8'd7, cyc, bok);
        check("after_rst_latency", cyc, 32'd6);
        check("after_rst_sum",     {13'd0, sum}, 32'd14);
        tick();

        // stall after 3 beats of 10
        start = 1'b1; n = 8'd10; s_data = 8'd10; s_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        s_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (done === 1'b1) got = 1'b1;
        end
`ifdef ACCM_SEQ_TIMEOUT_EN
        check("tmo_done", {31'd0, got}, 32'd1);
        check("tmo_err",  {31'd0, err}, 32'd1);
        check("tmo_sum",  {13'd0, sum}, 32'd30);
        check("tmo_ovf",  {31'd0, ovf}, 32'd0);
`else
        check("tmo_no_done", {31'd0, got}, 32'd0);
        check("tmo_err_low", {31'd0, err}, 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
